// File: rtl/sawtooth_pkg.sv
// Shared state encoding and default widths for the sawtooth ramp monitor.
package sawtooth_pkg;

  localparam int unsigned DefaultW       = 8;
  localparam int unsigned DefaultCw      = 24;
  localparam int unsigned DefaultMaxStep = 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SEEK = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Period counter: synchronous load-to-1, increment, saturation at all-ones.
module sat_counter #(
  parameter int unsigned CW = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o
);

  logic [CW-1:0] cnt_d, cnt_q;

  assign full_o = &cnt_q;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(1);
    end else if (inc_i && !full_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sawtooth_monitor.sv
// Receive-side checker for an 8-bit sawtooth ramp: measures period/peak/floor per
// cycle, flags illegal upward steps and over-long cycles, and reports period lock.
module sawtooth_monitor
  import sawtooth_pkg::*;
#(
  parameter int unsigned W       = DefaultW,
  parameter int unsigned CW      = DefaultCw,
  parameter int unsigned MAXSTEP = DefaultMaxStep
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  val,
  output logic [CW-1:0] period,
  output logic [W-1:0]  peak,
  output logic [W-1:0]  floor,
  output logic          meas_valid,
  output logic          locked,
  output logic          err,
  output logic          timeout
);

  localparam logic [W-1:0] MaxStepW = W'(MAXSTEP);

  state_e        state_d, state_q;
  logic [W-1:0]  s_q, prev_q;
  logic          s_vld_q;
  logic [CW-1:0] period_d, period_q;
  logic [W-1:0]  peak_d, peak_q;
  logic [W-1:0]  floor_d, floor_q;
  logic          mv_d, mv_q;
  logic          locked_d, locked_q;
  logic          err_d, err_q;
  logic [CW-1:0] last_d, last_q;
  logic          have_last_d, have_last_q;

  logic          wrap, step_err, active;
  logic [W-1:0]  rise;
  logic [CW-1:0] cnt;
  logic          cnt_full;
  logic          cnt_load, cnt_inc;

  assign wrap     = s_q < prev_q;
  assign rise     = s_q - prev_q;
  assign step_err = (s_q > prev_q) && (rise > MaxStepW);
  assign active   = (state_q == ST_SEEK) || (state_q == ST_RUN);

  assign cnt_load = active && wrap;
  assign cnt_inc  = (state_q == ST_RUN) && !wrap && !step_err;

  sat_counter #(
    .CW(CW)
  ) u_cnt (
    .clk_i (clk),
    .rst_ni(rst),
    .load_i(cnt_load),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .full_o(cnt_full)
  );

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    peak_d      = peak_q;
    floor_d     = floor_q;
    mv_d        = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    unique case (state_q)
      ST_INIT: begin
        // prev only holds a real sample once s has been loaded at least once.
        if (s_vld_q) state_d = ST_SEEK;
      end
      ST_SEEK: begin
        if (step_err) begin
          err_d       = 1'b1;
          locked_d    = 1'b0;
          have_last_d = 1'b0;
        end else if (wrap) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step_err) begin
          err_d       = 1'b1;
          locked_d    = 1'b0;
          have_last_d = 1'b0;
          state_d     = ST_SEEK;
        end else if (wrap) begin
          if (!cnt_full) begin
            period_d    = cnt;
            peak_d      = prev_q;
            floor_d     = s_q;
            mv_d        = 1'b1;
            locked_d    = (cnt == last_q) && have_last_q;
            last_d      = cnt;
            have_last_d = 1'b1;
          end else begin
            // A saturated cycle has no trustworthy length; drop lock history.
            locked_d    = 1'b0;
            have_last_d = 1'b0;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      s_q         <= '0;
      prev_q      <= '0;
      s_vld_q     <= 1'b0;
      period_q    <= '0;
      peak_q      <= '0;
      floor_q     <= '0;
      mv_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= val;
      prev_q      <= s_q;
      s_vld_q     <= 1'b1;
      period_q    <= period_d;
      peak_q      <= peak_d;
      floor_q     <= floor_d;
      mv_q        <= mv_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
    end
  end

  assign period     = period_q;
  assign peak       = peak_q;
  assign floor      = floor_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = cnt_full;

endmodule

// File: tb/tb_sawtooth_monitor.sv
// Directed bench for sawtooth_monitor: a CW=24 instance for ramp/lock/error/reset
// scenarios and a CW=12 instance sharing the stimulus for the timeout scenario.
module tb_sawtooth_monitor;

  logic        clk;
  logic        rst;
  logic [7:0]  val;

  logic [23:0] period;
  logic [7:0]  peak, floor;
  logic        meas_valid, locked, err, timeout;

  logic [11:0] period1;
  logic [7:0]  peak1, floor1;
  logic        meas_valid1, locked1, err1, timeout1;

  int checks = 0;
  int errors = 0;

  int          mv_cnt, err_cnt, mv1_cnt, mv_before;
  logic [31:0] cap_period, cap_peak, cap_floor, cap_locked;

  sawtooth_monitor #(
    .W(8), .CW(24), .MAXSTEP(1)
  ) dut (
    .clk(clk), .rst(rst), .val(val),
    .period(period), .peak(peak), .floor(floor),
    .meas_valid(meas_valid), .locked(locked), .err(err), .timeout(timeout)
  );

  sawtooth_monitor #(
    .W(8), .CW(12), .MAXSTEP(1)
  ) dut12 (
    .clk(clk), .rst(rst), .val(val),
    .period(period1), .peak(peak1), .floor(floor1),
    .meas_valid(meas_valid1), .locked(locked1), .err(err1), .timeout(timeout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample per clock; outputs are sampled 1ns after the edge.
  task automatic tick(input logic [7:0] v);
    val = v;
    @(posedge clk);
    #1;
    if (meas_valid) begin
      mv_cnt++;
      cap_period = 32'(period);
      cap_peak   = 32'(peak);
      cap_floor  = 32'(floor);
      cap_locked = 32'(locked);
    end
    if (err) err_cnt++;
    if (meas_valid1) mv1_cnt++;
  endtask

  task automatic ramp(input int lo, input int hi, input int hold);
    for (int v = lo; v <= hi; v++) begin
      for (int h = 0; h < hold; h++) begin
        logic [31:0] vv;
        vv = v;
        tick(vv[7:0]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_peak"}, 32'(peak), 0);
    check({tag, "_floor"}, 32'(floor), 0);
    check({tag, "_mv"}, 32'(meas_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mv_cnt = 0; err_cnt = 0; mv1_cnt = 0;
    cap_period = 0; cap_peak = 0; cap_floor = 0; cap_locked = 0;
  endtask

  initial begin
    rst = 1'b1;
    val = 8'd0;
    mv_cnt = 0; err_cnt = 0; mv1_cnt = 0; mv_before = 0;
    cap_period = 0; cap_peak = 0; cap_floor = 0; cap_locked = 0;
    #2;

    // Full ramp 0..255, one step per clock.
    do_reset("rst1");
    ramp(0, 255, 1);
    ramp(0, 255, 1);
    check("ramp_first_wrap_no_mv", 32'(mv_cnt), 0);
    ramp(0, 255, 1);
    check("ramp_mv_count", 32'(mv_cnt), 1);
    check("ramp_period", cap_period, 256);
    check("ramp_peak", cap_peak, 255);
    check("ramp_floor", cap_floor, 0);
    check("ramp_locked_first", cap_locked, 0);
    ramp(0, 255, 1);
    check("ramp_mv_count2", 32'(mv_cnt), 2);
    check("ramp_locked_second", cap_locked, 1);
    check("ramp_locked_level", 32'(locked), 1);
    check("ramp_no_err", 32'(err_cnt), 0);

    // Each value held 20 clocks.
    do_reset("rst2");
    for (int i = 0; i < 4; i++) ramp(0, 255, 20);
    check("hold_mv_count", 32'(mv_cnt), 2);
    check("hold_period", cap_period, 5120);
    check("hold_locked", 32'(locked), 1);

    // Partial-range ramp 5..200.
    do_reset("rst3");
    for (int i = 0; i < 3; i++) ramp(5, 200, 1);
    check("part_mv_count", 32'(mv_cnt), 1);
    check("part_period", cap_period, 196);
    check("part_peak", cap_peak, 200);
    check("part_floor", cap_floor, 5);

    // Locked ramp, then an illegal jump 10 -> 13.
    do_reset("rst4");
    for (int i = 0; i < 4; i++) ramp(0, 255, 1);
    ramp(0, 10, 1);
    check("errsc_locked_before", 32'(locked), 1);
    mv_before = mv_cnt;
    ramp(13, 255, 1);
    check("errsc_err_pulses", 32'(err_cnt), 1);
    check("errsc_locked_fell", 32'(locked), 0);
    check("errsc_period_hold", 32'(period), 256);
    check("errsc_peak_hold", 32'(peak), 255);
    check("errsc_floor_hold", 32'(floor), 0);
    check("errsc_no_mv_after_err", 32'(mv_cnt), 32'(mv_before));
    ramp(0, 255, 1);
    check("errsc_seek_wrap_no_mv", 32'(mv_cnt), 32'(mv_before));
    ramp(0, 255, 1);
    check("errsc_recover_mv", 32'(mv_cnt), 32'(mv_before + 1));
    check("errsc_recover_period", cap_period, 256);
    check("errsc_recover_unlocked", cap_locked, 0);

    // CW=12 instance: lock, then hold until the counter saturates.
    do_reset("rst5");
    for (int i = 0; i < 4; i++) ramp(0, 255, 1);
    check("to_locked", 32'(locked1), 1);
    ramp(0, 7, 1);
    for (int i = 0; i < 4087; i++) tick(8'd7);
    check("to_before_sat", 32'(timeout1), 0);
    tick(8'd7);
    check("to_at_sat", 32'(timeout1), 1);
    check("to_locked_kept", 32'(locked1), 1);
    for (int i = 0; i < 10; i++) tick(8'd7);
    check("to_still_sat", 32'(timeout1), 1);
    mv_before = mv1_cnt;
    tick(8'd0);
    tick(8'd0);
    check("to_wrap_cleared", 32'(timeout1), 0);
    check("to_wrap_unlocked", 32'(locked1), 0);
    tick(8'd0);
    tick(8'd0);
    check("to_wrap_no_mv", 32'(mv1_cnt), 32'(mv_before));

    // Asynchronous reset in the middle of a locked ramp.
    do_reset("rst6");
    for (int i = 0; i < 4; i++) ramp(0, 255, 1);
    ramp(0, 100, 1);
    check("mid_locked_before", 32'(locked), 1);
    rst = 1'b0;
    #1;
    check_zero("mid_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    mv_cnt = 0; err_cnt = 0;
    ramp(101, 255, 1);
    ramp(0, 255, 1);
    check("mid_no_spurious_mv", 32'(mv_cnt), 0);
    check("mid_no_spurious_err", 32'(err_cnt), 0);
    ramp(0, 255, 1);
    check("mid_recover_mv", 32'(mv_cnt), 1);
    check("mid_recover_period", cap_period, 256);
    check("mid_recover_unlocked", cap_locked, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sawtooth_monitor.md
# sawtooth_monitor

Receive-side checker for the 8-bit ramp produced by the team's sawtooth generator. It samples the ramp value every clock and detects each wrap-around, where the value drops. For every complete cycle it measures the period in clocks, the peak value and the floor value. It also flags non-monotonic steps and cycles that run too long, and asserts a lock indication when consecutive periods match. It sits beside the generator on the Mojo fabric as a self-check and debug block.

## Interface
- W, 8, sample width
- CW, 24, period counter width; must be at least W+1
- MAXSTEP, 1, largest legal upward step between consecutive samples
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- val  in  W  ramp sample, unsigned, valid every cycle
- period  out  CW  clocks in the last measured cycle
- peak  out  W  last sample before the measured wrap
- floor  out  W  first sample after the measured wrap
- meas_valid  out  1  one-cycle pulse when period/peak/floor update
- locked  out  1  level; two consecutive measured periods were equal
- err  out  1  one-cycle pulse on an illegal upward step
- timeout  out  1  level; cycle counter saturated since the last wrap

## Operation
- Input register: `s <= val` on each edge. `prev <= s`.
- Wrap condition: `s < prev`, unsigned. Equal values are holds and are legal.
- Step error: `s > prev` and `s - prev > MAXSTEP`.
- States:
  - INIT: no valid `prev`. Go to SEEK after the first registered sample.
  - SEEK: wait for the first wrap. No measurement is made. On wrap, set `cnt <= 1` and go to RUN.
  - RUN: on each non-wrap cycle, `cnt <= cnt+1`, saturating at 2^CW-1.
- Wrap in RUN with `cnt` not saturated:
  - `period <= cnt`, `peak <= prev`, `floor <= s`.
  - Pulse `meas_valid`.
  - `locked <= (cnt == last_period) && have_last`.
  - `last_period <= cnt`, `have_last <= 1`.
  - `cnt <= 1`.
- Wrap in RUN with `cnt` saturated:
  - No `meas_valid`.
  - Clear `locked`, clear `have_last`, clear `timeout`.
  - `cnt <= 1`. Stay in RUN.
- `timeout` is high from the edge where `cnt` reaches 2^CW-1 until the next wrap.
- Step error in any state except INIT:
  - Pulse `err`.
  - Clear `locked` and `have_last`.
  - Go to SEEK, discarding the partial cycle.
  - Outputs period/peak/floor hold their values.
- Step error and wrap are mutually exclusive by definition.
- Reset, including mid-operation: every register and output goes to 0 and the state goes to INIT.

## Timing
- Reset values: period=0, peak=0, floor=0, meas_valid=0, locked=0, err=0, timeout=0.
- Latency: a wrapped value presented on `val` before edge E is registered at E. `meas_valid`, `err` and updated outputs are registered at E+1 and are visible in the cycle after E+1.
- period, peak and floor change only on edges that assert `meas_valid`.
- `locked` changes only on measurement, error or saturated-wrap edges.
- The first measurement requires two wraps after reset or after an error.
- Period definition: `cnt` counts the wrap sample as 1. A ramp 0..N-1 stepping every clock gives period=N.

## Structure
- Package `sawtooth_pkg`: state encoding constants (ST_INIT, ST_SEEK, ST_RUN) and default widths.
- One sub-module, `sat_counter` (parameter CW): synchronous load-to-1, increment and saturate, with a `full` output that drives `timeout`.
- Comparison, lock and output registers stay in the top level.

## Test plan
All scenarios use W=8, MAXSTEP=1, CW=24 unless noted.
- Reset, then ramp 0..255 stepping every clock, repeated:
  - No output at the first wrap.
  - At the second wrap: meas_valid with period=256, peak=255, floor=0, locked=0.
  - At the third wrap: locked=1.
- Each value held 20 clocks, ramp 0..255: period=5120 and locked after the third wrap.
- Ramp 5..200 repeated: period=196, peak=200, floor=5.
- Locked ramp, then a jump 10→13:
  - err pulses for one cycle, locked falls, outputs hold.
  - The next wrap gives no meas_valid.
  - The following wrap gives a valid period with locked=0.
- CW=12, val held at 7 after lock:
  - timeout rises when cnt reaches 4095.
  - val then goes to 0: no meas_valid, timeout and locked are 0.
- Assert rst mid-ramp: all outputs are 0 immediately (asynchronous). After release, recovery follows the INIT/SEEK sequence with no spurious meas_valid or err.
